// File: rtl/dsm_pkg.sv
// Shared constants for the delta-sigma decimator: CIC order, default ratio,
// register width rule and the DSM 20-bit full-scale codes.
package dsm_pkg;

    localparam int R_LOG2_DEF = 6;
    localparam int ORDER      = 3;

    localparam logic [19:0] VIN_FS      = 20'h0_8000;
    localparam logic [19:0] VIN_FS_HALF = 20'h0_4000;

    // One sign bit plus headroom for the R^ORDER DC gain of a +/-1 input.
    function automatic int cic_width(input int r_log2);
        return 2 + ORDER * r_log2;
    endfunction

endpackage

// File: rtl/dsm_cic_integ.sv
// One CIC integrator: W-bit wrapping accumulator with enable and synchronous
// active-low clear; sum_o is the post-update value so stages chain in one edge.
module dsm_cic_integ #(
    parameter int W = 20
) (
    input  logic         clock,
    input  logic         clear_n_i,
    input  logic         en_i,
    input  logic [W-1:0] in_i,
    output logic [W-1:0] sum_o
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q + in_i;
    end

    // Wrap-around is intentional; the combs recover the true difference modulo 2^W.
    always_ff @(posedge clock) begin
        if (!clear_n_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

    assign sum_o = acc_d;

endmodule

// File: rtl/dsm_decim.sv
// 3rd-order CIC decimator for a 1-bit DSM stream, ratio 2^R_LOG2, with a
// valid/ready output port. Define DSM_DECIM_OVR_EN to drop stalled results and flag overrun.
module dsm_decim
    import dsm_pkg::*;
#(
    parameter int R_LOG2 = R_LOG2_DEF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pwm,
    input  logic        pwm_valid,
    output logic [19:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overrun
);

    localparam int W     = cic_width(R_LOG2);
    localparam int SHIFT = ORDER * R_LOG2 - 15;
    localparam logic [R_LOG2-1:0] CNT_LAST = '1;

    logic [W-1:0] sampleX;
    logic [W-1:0] integIn  [ORDER];
    logic [W-1:0] integSum [ORDER];

    logic [R_LOG2-1:0] decimCnt_q, decimCnt_d;
    logic [W-1:0]      decim_q, decim_d;
    logic              decimEvt_q, decimEvt_d;

    logic [W-1:0] combDly1_q, combDly1_d;
    logic [W-1:0] combDly2_q, combDly2_d;
    logic [W-1:0] combDly3_q, combDly3_d;
    logic [W-1:0] comb1, comb2, comb3;
    logic signed [W+19:0] combExt;
    logic [19:0]  newSample;

    logic [19:0] outData_q, outData_d;
    logic        outValid_q, outValid_d;
    logic        handshake;

    assign sampleX = pwm ? W'(1) : '1;

    assign integIn[0] = sampleX;
    for (genvar i = 1; i < ORDER; i++) begin : gIntegLink
        assign integIn[i] = integSum[i-1];
    end

    for (genvar i = 0; i < ORDER; i++) begin : gInteg
        dsm_cic_integ #(
            .W(W)
        ) uInteg (
            .clock     (clock),
            .clear_n_i (reset_n),
            .en_i      (pwm_valid),
            .in_i      (integIn[i]),
            .sum_o     (integSum[i])
        );
    end

    // The decimation register captures integrator 3 including the sample accepted on this edge.
    always_comb begin
        decimCnt_d = decimCnt_q;
        decim_d    = decim_q;
        decimEvt_d = 1'b0;
        if (pwm_valid) begin
            decimCnt_d = decimCnt_q + 1'b1;
            if (decimCnt_q == CNT_LAST) begin
                decim_d    = integSum[ORDER-1];
                decimEvt_d = 1'b1;
            end
        end
    end

    always_comb begin
        comb1   = decim_q - combDly1_q;
        comb2   = comb1 - combDly2_q;
        comb3   = comb2 - combDly3_q;
        combExt = {{20{comb3[W-1]}}, comb3};
        newSample = 20'(combExt >>> SHIFT);
    end

    always_comb begin
        combDly1_d = combDly1_q;
        combDly2_d = combDly2_q;
        combDly3_d = combDly3_q;
        if (decimEvt_q) begin
            combDly1_d = decim_q;
            combDly2_d = comb1;
            combDly3_d = comb2;
        end
    end

    assign handshake = outValid_q && out_ready;

`ifdef DSM_DECIM_OVR_EN
    logic overrun_q, overrun_d;

    // A result arriving into a stalled port is discarded so the consumer keeps the older sample.
    always_comb begin
        outData_d  = outData_q;
        outValid_d = outValid_q;
        overrun_d  = overrun_q;
        if (decimEvt_q) begin
            if (outValid_q && !out_ready) begin
                overrun_d = 1'b1;
            end else begin
                outData_d  = newSample;
                outValid_d = 1'b1;
            end
        end else if (handshake) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    always_comb begin
        outData_d  = outData_q;
        outValid_d = outValid_q;
        if (decimEvt_q) begin
            outData_d  = newSample;
            outValid_d = 1'b1;
        end else if (handshake) begin
            outValid_d = 1'b0;
        end
    end

    assign overrun = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            decimCnt_q <= '0;
            decim_q    <= '0;
            decimEvt_q <= 1'b0;
            combDly1_q <= '0;
            combDly2_q <= '0;
            combDly3_q <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
        end else begin
            decimCnt_q <= decimCnt_d;
            decim_q    <= decim_d;
            decimEvt_q <= decimEvt_d;
            combDly1_q <= combDly1_d;
            combDly2_q <= combDly2_d;
            combDly3_q <= combDly3_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
        end
    end

    assign out_data  = outData_q;
    assign out_valid = outValid_q;

endmodule
